// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 16x-oversampled 8N1 receive front end that feeds the RX buffer (rbr/newdata).
// Optional macro UART_PARITY_EN adds a parity bit (sense set by PARITY_ODD) between data and stop.
module uart_rx_sampler #(
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned NEWDATA_HOLD = 16,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       rcvbuf_clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rbr,
    output logic       newdata,
    output logic       framing_err,
    output logic       parity_err,
    output logic       rx_busy
);

    if (OVERSAMPLE != 16) begin : g_bad_oversample
        $error("uart_rx_sampler: OVERSAMPLE must be 16");
    end
    if (NEWDATA_HOLD < 1 || NEWDATA_HOLD > OVERSAMPLE) begin : g_bad_hold
        $error("uart_rx_sampler: NEWDATA_HOLD must be 1..OVERSAMPLE");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_rx_sampler: PARITY_ODD must be 0 or 1");
    end

    localparam int unsigned CW  = $clog2(OVERSAMPLE);
    localparam int unsigned HCW = (NEWDATA_HOLD > 1) ? $clog2(NEWDATA_HOLD) : 1;
    localparam logic [CW-1:0]  MID_CNT   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]  LAST_CNT  = CW'(OVERSAMPLE - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(NEWDATA_HOLD - 1);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_e;

    state_e         state_q, state_d;
    logic           s1_q, s2_q;
    logic [1:0]     sync_fill_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bitidx_q, bitidx_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [7:0]     rbr_q, rbr_d;
    logic           ferr_q, ferr_d;
    logic           newdata_q, newdata_d;
    logic [HCW-1:0] holdcnt_q, holdcnt_d;
    logic           load_hold;
    logic           sync_ok;
`ifdef UART_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);
    logic           perr_q, perr_d;
    logic           pbad_q, pbad_d;
`endif

    // s1/s2 reset to idle-high, so WAIT_IDLE must not trust s2 until it holds a real line sample.
    assign sync_ok = sync_fill_q[1];

    always_ff @(posedge rcvbuf_clk) begin
        if (reset) begin
            state_q     <= ST_WAIT_IDLE;
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            sync_fill_q <= '0;
            cnt_q       <= '0;
            bitidx_q    <= '0;
            shreg_q     <= '0;
            rbr_q       <= '0;
            ferr_q      <= 1'b0;
            newdata_q   <= 1'b0;
            holdcnt_q   <= '0;
`ifdef UART_PARITY_EN
            perr_q      <= 1'b0;
            pbad_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s1_q        <= rxd;
            s2_q        <= s1_q;
            sync_fill_q <= {sync_fill_q[0], 1'b1};
            cnt_q       <= cnt_d;
            bitidx_q    <= bitidx_d;
            shreg_q     <= shreg_d;
            rbr_q       <= rbr_d;
            ferr_q      <= ferr_d;
            newdata_q   <= newdata_d;
            holdcnt_q   <= holdcnt_d;
`ifdef UART_PARITY_EN
            perr_q      <= perr_d;
            pbad_q      <= pbad_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitidx_d  = bitidx_q;
        shreg_d   = shreg_q;
        rbr_d     = rbr_q;
        ferr_d    = ferr_q;
        load_hold = 1'b0;
`ifdef UART_PARITY_EN
        perr_d    = perr_q;
        pbad_d    = pbad_q;
`endif
        case (state_q)
            ST_WAIT_IDLE: begin
                if (sync_ok && s2_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!s2_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == MID_CNT) begin
                    cnt_d = '0;
                    if (!s2_q) begin
                        state_d  = ST_DATA;
                        bitidx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    shreg_d  = {s2_q, shreg_q[7:1]};
                    bitidx_d = bitidx_q + 3'd1;
                    if (bitidx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    pbad_d  = (s2_q != ((^shreg_q) ^ PAR_SENSE));
                    if (pbad_d) begin
                        perr_d = 1'b1;
                    end
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (s2_q) begin
                        rbr_d     = shreg_q;
                        ferr_d    = 1'b0;
                        load_hold = 1'b1;
`ifdef UART_PARITY_EN
                        perr_d    = pbad_q;
`endif
                        state_d   = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase
    end

    // newdata hold timer runs on its own so the FSM can already be hunting the next start bit.
    always_comb begin
        newdata_d = newdata_q;
        holdcnt_d = holdcnt_q;
        if (load_hold) begin
            newdata_d = 1'b1;
            holdcnt_d = HOLD_LAST;
        end else if (newdata_q) begin
            if (holdcnt_q == '0) begin
                newdata_d = 1'b0;
            end else begin
                holdcnt_d = holdcnt_q - HCW'(1);
            end
        end
    end

    always_comb begin
        rx_busy = !(state_q inside {ST_WAIT_IDLE, ST_IDLE});
    end

    assign rbr         = rbr_q;
    assign newdata     = newdata_q;
    assign framing_err = ferr_q;
`ifdef UART_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: frames are queued when driven and checked on each newdata rise.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

    localparam int unsigned HOLD = 16;
`ifdef UART_PARITY_EN
    localparam int unsigned STOP_EDGE = 171;
`else
    localparam int unsigned STOP_EDGE = 155;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rbr;
    logic       newdata;
    logic       framing_err;
    logic       parity_err;
    logic       rx_busy;

    uart_rx_sampler #(
        .OVERSAMPLE  (16),
        .NEWDATA_HOLD(HOLD),
        .PARITY_ODD  (0)
    ) dut (
        .rcvbuf_clk (clk),
        .reset      (reset),
        .rxd        (rxd),
        .rbr        (rbr),
        .newdata    (newdata),
        .framing_err(framing_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        int unsigned at_cyc;
        logic        perr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    // Called at a negedge; edge 1 of the frame is the next posedge.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic exp_ok);
        exp_t e;
        if (exp_ok) begin
            e.data   = d;
            e.at_cyc = cyc + STOP_EDGE;
            e.perr   = 1'b0;
            sb.push_back(e);
        end
        send_head(d);
`ifdef UART_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_bit);
    endtask

`ifdef UART_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par, input logic exp_perr);
        exp_t e;
        e.data   = d;
        e.at_cyc = cyc + STOP_EDGE;
        e.perr   = exp_perr;
        sb.push_back(e);
        send_head(d);
        send_bit(par);
        send_bit(1'b1);
    endtask
`endif

    // newdata monitor: pops the scoreboard on each rising edge and checks pulse width on the fall.
    initial begin
        logic        nd_prev;
        logic        busy_prev;
        int unsigned rise_cyc;
        exp_t        e;
        nd_prev   = 1'b0;
        busy_prev = 1'b0;
        rise_cyc  = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (newdata && !nd_prev) begin
                    rise_cyc = cyc;
                    if (sb.size() == 0) begin
                        chk("nd_unexpected", {31'd0, newdata}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rbr_on_nd", {24'd0, rbr}, {24'd0, e.data});
                        chk("nd_rise_edge", cyc, e.at_cyc);
                        chk("ferr_on_nd", {31'd0, framing_err}, 32'd0);
                        chk("perr_on_nd", {31'd0, parity_err}, {31'd0, e.perr});
                        chk("busy_before_stop", {31'd0, busy_prev}, 32'd1);
                        chk("busy_after_stop", {31'd0, rx_busy}, 32'd0);
                    end
                end
                if (!newdata && nd_prev) begin
                    chk("nd_width", cyc - rise_cyc, HOLD);
                end
            end
            nd_prev   = newdata;
            busy_prev = rx_busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_rbr", {24'd0, rbr}, 32'd0);
        chk("rst_newdata", {31'd0, newdata}, 32'd0);
        chk("rst_ferr", {31'd0, framing_err}, 32'd0);
        chk("rst_perr", {31'd0, parity_err}, 32'd0);
        chk("rst_busy", {31'd0, rx_busy}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // single frame
        send_frame(8'hA5, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        chk("t1_pending", sb.size(), 32'd0);
        chk("t1_rbr", {24'd0, rbr}, 32'h A5);
        chk("t1_nd_low", {31'd0, newdata}, 32'd0);

        // back-to-back frames, no idle gap
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        chk("t2_pending", sb.size(), 32'd0);
        chk("t2_rbr", {24'd0, rbr}, 32'h C3);

        // 5-clock glitch
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        chk("t3_busy_in_start", {31'd0, rx_busy}, 32'd1);
        repeat (10) @(negedge clk);
        chk("t3_busy_after", {31'd0, rx_busy}, 32'd0);
        repeat (30) @(negedge clk);
        chk("t3_rbr", {24'd0, rbr}, 32'h C3);
        chk("t3_ferr", {31'd0, framing_err}, 32'd0);
        chk("t3_pending", sb.size(), 32'd0);

        // bad stop bit followed by break, then a good frame
        send_frame(8'h55, 1'b0, 1'b0);
        chk("t4_ferr_set", {31'd0, framing_err}, 32'd1);
        chk("t4_busy_break", {31'd0, rx_busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("t4_ferr_held", {31'd0, framing_err}, 32'd1);
        chk("t4_busy_held", {31'd0, rx_busy}, 32'd0);
        chk("t4_rbr_kept", {24'd0, rbr}, 32'h C3);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h12, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        chk("t4_pending", sb.size(), 32'd0);
        chk("t4_rbr", {24'd0, rbr}, 32'h 12);
        chk("t4_ferr_clr", {31'd0, framing_err}, 32'd0);

        // reset at edge 60 of an all-zero frame
        rxd = 1'b0;
        repeat (59) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_rbr", {24'd0, rbr}, 32'd0);
        chk("t5_newdata", {31'd0, newdata}, 32'd0);
        chk("t5_ferr", {31'd0, framing_err}, 32'd0);
        chk("t5_perr", {31'd0, parity_err}, 32'd0);
        chk("t5_busy", {31'd0, rx_busy}, 32'd0);
        repeat (84) @(negedge clk);
        chk("t5_busy_tail", {31'd0, rx_busy}, 32'd0);
        rxd = 1'b1;
        repeat (46) @(negedge clk);
        chk("t5_no_decode", sb.size(), 32'd0);
        chk("t5_rbr_still0", {24'd0, rbr}, 32'd0);
        send_frame(8'h81, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        chk("t5_pending", sb.size(), 32'd0);
        chk("t5_rbr_after", {24'd0, rbr}, 32'h 81);

`ifdef UART_PARITY_EN
        // even parity: 0x07 has three ones, so parity bit 1 is correct
        send_frame_par(8'h07, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        send_frame_par(8'h07, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        chk("t6_pending", sb.size(), 32'd0);
        chk("t6_perr_sticky", {31'd0, parity_err}, 32'd1);
        chk("t6_rbr", {24'd0, rbr}, 32'h 07);
`endif

        repeat (10) @(negedge clk);
        chk("final_pending", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- RS-232 receive front end, sitting directly upstream of the 10K receive buffer.
- Oversamples the asynchronous rxd line at 16x baud, on the same 16x clock the buffer's control FSM uses.
- Deframes 8N1 characters, LSB first, into the 8-bit RX buffer rbr.
- Signals each completed character with a newdata pulse; the downstream stage triggers on its falling edge.

Parameters:
- OVERSAMPLE, 16, clocks per bit. Fixed at 16; the mid-bit and sample counts below assume this value.
- NEWDATA_HOLD, 16, number of clocks newdata stays high per character (1..OVERSAMPLE).
- PARITY_ODD, 0, parity sense when UART_PARITY_EN is defined: 0 = even, 1 = odd.

Ports:
- rcvbuf_clk  input  1  16x-baud clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial line; idle high.
- rbr  output  8  last good received character; bit 0 is the first data bit on the line.
- newdata  output  1  high for NEWDATA_HOLD clocks when rbr is updated.
- framing_err  output  1  sticky; set on a bad stop bit, cleared by the next good frame or by reset.
- parity_err  output  1  sticky parity error; tied 0 when UART_PARITY_EN is not defined.
- rx_busy  output  1  high in every state except IDLE and WAIT_IDLE.

Behaviour:
- Clock and reset: single clock rcvbuf_clk; reset is synchronous and active-high, sampled on the rising edge of rcvbuf_clk.
- Reset values:
  - rbr=0, newdata=0, framing_err=0, parity_err=0, rx_busy=0.
  - Synchronizer flops s1 and s2 = 1; state = WAIT_IDLE.
  - Counters cnt, bitidx and holdcnt = 0.
- Input synchronizer: rxd passes through 2 flops (s1, s2). The FSM only ever looks at s2.
- Edge numbering: edge 1 is the first rising edge that captures rxd=0 into s1.
- WAIT_IDLE: go to IDLE once s2=1. This blocks a false start when reset is released mid-frame or during a break.
- IDLE: on s2=0, go to START with cnt=0 (edge 3).
- START:
  - cnt increments each clock.
  - When cnt==7 (mid start bit, edge 11): if s2=0, go to DATA with cnt=0 and bitidx=0; otherwise treat it as a glitch and return to IDLE. No outputs change on a glitch.
- DATA:
  - When cnt==15, shift s2 into shreg LSB-first, reset cnt to 0 and increment bitidx.
  - Data bit i is sampled on edge 27+16i, so bit 7 is sampled on edge 139.
  - After bitidx reaches 7, go to PARITY (macro defined) or STOP.
- STOP: sample on edge 155 (edge 171 when parity is enabled).
  - s2=1 (good stop): rbr<=shreg, framing_err<=0, newdata<=1, holdcnt loaded; go to IDLE.
  - s2=0 (bad stop): framing_err<=1; rbr and newdata unchanged; go to WAIT_IDLE.
- newdata:
  - Rises after the good-stop edge and stays high for exactly NEWDATA_HOLD clocks, counted by holdcnt independently of the FSM.
  - Minimum frame length is 160 clocks, so the hold never overlaps the next character.
- rbr latency: rbr and newdata change on the same edge; rbr stays stable until the next good stop.
- Back-to-back frames: a start bit arriving immediately after the stop-bit sample is accepted. IDLE is re-entered at the stop-bit mid-point, giving 8 clocks of margin.
- Break (rxd held low): produces one framing_err and no newdata; the block re-arms only after the line returns high.
- Reset mid-frame: partial data is discarded, all outputs return to their reset values, and the FSM goes to WAIT_IDLE.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - An extra PARITY state sits between DATA and STOP, sampling at cnt==15 (edge 155).
  - Expected parity = ^shreg ^ PARITY_ODD. On mismatch parity_err<=1.
  - The character is still delivered if the stop bit is good. A good frame with correct parity clears parity_err.
- Undefined: no PARITY state exists; parity_err is constant 0; frames are 8N1.

Test Plan:
1. Reset, then send 8N1 0xA5 with rxd idle high. Required: newdata rises after edge 155 and falls after edge 171; rbr=0xA5; framing_err=0; rx_busy falls at edge 155.
2. Send 0x3C immediately followed by 0xC3 with no idle gap. Required: two newdata pulses 160 clocks apart; rbr=0x3C, then 0xC3.
3. Drive rxd low for 5 clocks only. Required: the START check at edge 11 sees high, FSM returns to IDLE; newdata=0, rbr unchanged, framing_err=0.
4. Send 0x55 with the stop bit driven 0, keep the line low for 40 clocks, then send 0x12. Required: framing_err=1 after edge 155; no pulse for 0x55; after the line returns high, 0x12 is received; framing_err clears and rbr=0x12.
5. Assert reset for 1 clock at edge 60 of a frame while rxd is low. Required: outputs are zero; the remaining frame bits are not decoded; the next full frame 0x81 gives rbr=0x81.
6. With UART_PARITY_EN defined and PARITY_ODD=0, send 0x07 with parity bit 1, then 0x07 with parity bit 0. Required: first frame gives parity_err=0; second gives parity_err=1; both deliver rbr=0x07; newdata rises after edge 171.
